// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB init sequencer: FSM states,
// table entry layout and OV7670 device IDs.
package sccb_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_RELEASE,
      S_DELAY,
      S_DONE,
      S_ERROR,
      S_VISSUE,
      S_VWAIT,
      S_VRELEASE
   } state_t;

   localparam int unsigned ENTRY_W = 16;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } entry_t;

   localparam logic [7:0] MARK_ADDR  = 8'hFF;
   localparam logic [7:0] END_DATA   = 8'hFF;
   localparam logic [7:0] OV7670_ID_W = 8'h42;
   localparam logic [7:0] OV7670_ID_R = 8'h43;

   // COM7 soft-reset bit self-clears, so a readback can never match
   localparam logic [7:0] RST_REG = 8'h12;
   localparam int unsigned RST_BIT = 7;

   function automatic logic is_end(input entry_t e);
      return (e.addr == MARK_ADDR) && (e.data == END_DATA);
   endfunction

endpackage

// File: rtl/sccb_init_rom.sv
// Synchronous (1-cycle) init table for the OV7670; entries are {sub_addr, data}.
// 0xFF in the address byte marks a delay (data = ms) or, with data 0xFF, the end.
module sccb_init_rom
   import sccb_pkg::*;
#(
   parameter int unsigned ROM_AW = 6
) (
   input  logic              PCLK,
   input  logic [ROM_AW-1:0] addr,
   output entry_t            entry
);

   always_ff @(posedge PCLK) begin
      case (addr)
         ROM_AW'(0): entry <= 16'h1280;
         ROM_AW'(1): entry <= 16'hFF0A;
         ROM_AW'(2): entry <= 16'h1101;
         ROM_AW'(3): entry <= 16'h1214;
         default:    entry <= {MARK_ADDR, END_DATA};
      endcase
   end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks the init ROM and issues one SCCB write per entry to CoreSCCB.
// Define SCCB_VERIFY_EN to read back and compare every write.
//
// state      | meaning
// -----------+------------------------------------------------------
// S_IDLE     | waiting for a go rising edge
// S_FETCH    | ROM word for index valid; decode write/delay/end
// S_ISSUE    | load address/data outputs, raise start
// S_WAIT     | start held until done or timeout
// S_RELEASE  | wait for done to fall, then advance
// S_DELAY    | millisecond delay down-counter
// S_DONE     | end marker reached, set init_done
// S_ERROR    | timeout/mismatch/overflow, drop busy
// S_VISSUE   | raise start for a readback of the last write
// S_VWAIT    | readback in flight, same done/timeout rules as S_WAIT
// S_VRELEASE | wait for done to fall, compare readback
module sccb_init_sequencer
   import sccb_pkg::*;
#(
   parameter int unsigned CLK_FREQ     = 8_000_000,
   parameter int unsigned TICKS_PER_MS = CLK_FREQ / 1000,
   parameter logic [7:0]  DEV_ADDR_W   = 8'h42,
   parameter int unsigned ROM_AW       = 6,
   parameter int unsigned TIMEOUT_CYC  = 100_000
) (
   input  logic              PCLK,
   input  logic              PRESETN,
   input  logic              go,
   output logic              start,
   output logic              rw,
   output logic [7:0]        ip_addr,
   output logic [7:0]        sub_addr,
   output logic [7:0]        data_in,
   input  logic              done,
   input  logic [7:0]        data_out,
   output logic              busy,
   output logic              init_done,
   output logic              error,
   output logic [ROM_AW-1:0] err_index
);

   localparam int unsigned DLY_W = $clog2(255 * TICKS_PER_MS + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

   state_t            state_q, state_d;
   logic [ROM_AW-1:0] index_q, index_d;
   entry_t            ent_q, ent_d;
   entry_t            rom_entry;
   logic [DLY_W-1:0]  dly_q, dly_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              go_q;
   logic              start_q, start_d;
   logic              rw_q, rw_d;
   logic [7:0]        ip_q, ip_d;
   logic [7:0]        sub_q, sub_d;
   logic [7:0]        din_q, din_d;
   logic              busy_q, busy_d;
   logic              init_done_q, init_done_d;
   logic              error_q, error_d;
   logic [ROM_AW-1:0] err_idx_q, err_idx_d;
   logic              advance;

`ifdef SCCB_VERIFY_EN
   logic [7:0]        rd_q, rd_d;
`else
   logic              unused_rd;
   assign unused_rd = ^data_out;
`endif

   // Address the ROM with the next index so its registered output always
   // matches index_q, which makes it valid on the first cycle of S_FETCH.
   sccb_init_rom #(.ROM_AW(ROM_AW)) u_rom (
      .PCLK  (PCLK),
      .addr  (index_d),
      .entry (rom_entry)
   );

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q     <= S_IDLE;
         index_q     <= '0;
         ent_q       <= '0;
         dly_q       <= '0;
         tmo_q       <= '0;
         go_q        <= 1'b0;
         start_q     <= 1'b0;
         rw_q        <= 1'b0;
         ip_q        <= '0;
         sub_q       <= '0;
         din_q       <= '0;
         busy_q      <= 1'b0;
         init_done_q <= 1'b0;
         error_q     <= 1'b0;
         err_idx_q   <= '0;
`ifdef SCCB_VERIFY_EN
         rd_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         ent_q       <= ent_d;
         dly_q       <= dly_d;
         tmo_q       <= tmo_d;
         go_q        <= go;
         start_q     <= start_d;
         rw_q        <= rw_d;
         ip_q        <= ip_d;
         sub_q       <= sub_d;
         din_q       <= din_d;
         busy_q      <= busy_d;
         init_done_q <= init_done_d;
         error_q     <= error_d;
         err_idx_q   <= err_idx_d;
`ifdef SCCB_VERIFY_EN
         rd_q        <= rd_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      ent_d       = ent_q;
      dly_d       = dly_q;
      tmo_d       = tmo_q;
      start_d     = start_q;
      rw_d        = rw_q;
      ip_d        = ip_q;
      sub_d       = sub_q;
      din_d       = din_q;
      busy_d      = busy_q;
      init_done_d = init_done_q;
      error_d     = error_q;
      err_idx_d   = err_idx_q;
      advance     = 1'b0;
`ifdef SCCB_VERIFY_EN
      rd_d        = rd_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (go && !go_q) begin
               init_done_d = 1'b0;
               error_d     = 1'b0;
               err_idx_d   = '0;
               index_d     = '0;
               busy_d      = 1'b1;
               state_d     = S_FETCH;
            end
         end
         S_FETCH: begin
            ent_d = rom_entry;
            if (is_end(rom_entry)) begin
               state_d = S_DONE;
            end else if (rom_entry.addr == MARK_ADDR) begin
               dly_d   = DLY_W'(rom_entry.data) * DLY_W'(TICKS_PER_MS);
               state_d = S_DELAY;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            ip_d    = DEV_ADDR_W;
            rw_d    = 1'b0;
            sub_d   = ent_q.addr;
            din_d   = ent_q.data;
            start_d = 1'b1;
            tmo_d   = TMO_W'(TIMEOUT_CYC - 1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // done is checked first so it wins over a same-cycle timeout
            if (done) begin
               start_d = 1'b0;
               state_d = S_RELEASE;
            end else if (tmo_q == '0) begin
               start_d   = 1'b0;
               error_d   = 1'b1;
               err_idx_d = index_q;
               state_d   = S_ERROR;
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
         end
         S_RELEASE: begin
            if (!done) begin
`ifdef SCCB_VERIFY_EN
               if (ent_q.addr == RST_REG && ent_q.data[RST_BIT])
                  advance = 1'b1;
               else
                  state_d = S_VISSUE;
`else
               advance = 1'b1;
`endif
            end
         end
         S_DELAY: begin
            if (dly_q == '0) advance = 1'b1;
            else             dly_d   = dly_q - 1'b1;
         end
         S_DONE: begin
            busy_d      = 1'b0;
            init_done_d = 1'b1;
            state_d     = S_IDLE;
         end
         S_ERROR: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
`ifdef SCCB_VERIFY_EN
         S_VISSUE: begin
            ip_d    = DEV_ADDR_W | 8'h01;
            rw_d    = 1'b1;
            start_d = 1'b1;
            tmo_d   = TMO_W'(TIMEOUT_CYC - 1);
            state_d = S_VWAIT;
         end
         S_VWAIT: begin
            if (done) begin
               start_d = 1'b0;
               rd_d    = data_out;
               state_d = S_VRELEASE;
            end else if (tmo_q == '0) begin
               start_d   = 1'b0;
               error_d   = 1'b1;
               err_idx_d = index_q;
               state_d   = S_ERROR;
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
         end
         S_VRELEASE: begin
            if (!done) begin
               if (rd_q != ent_q.data) begin
                  error_d   = 1'b1;
                  err_idx_d = index_q;
                  state_d   = S_ERROR;
               end else begin
                  advance = 1'b1;
               end
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // A table with no end marker must not loop forever through the ROM
      if (advance) begin
         if (&index_q) begin
            index_d   = '0;
            error_d   = 1'b1;
            err_idx_d = index_q;
            state_d   = S_ERROR;
         end else begin
            index_d = index_q + 1'b1;
            state_d = S_FETCH;
         end
      end
   end

   assign start     = start_q;
   assign rw        = rw_q;
   assign ip_addr   = ip_q;
   assign sub_addr  = sub_q;
   assign data_in   = din_q;
   assign busy      = busy_q;
   assign init_done = init_done_q;
   assign error     = error_q;
   assign err_index = err_idx_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Scoreboard bench for sccb_init_sequencer with a CoreSCCB-like done BFM.
// Build with SCCB_VERIFY_EN defined to also exercise the readback path.
module tb_sccb_init_sequencer;

   typedef struct packed {
      logic [7:0] ip;
      logic       rw;
      logic [7:0] sub;
      logic [7:0] dat;
   } txn_t;

   logic       PCLK = 1'b0;
   logic       PRESETN;
   logic       go;
   logic       start, rw, done;
   logic [7:0] ip_addr, sub_addr, data_in, data_out;
   logic       busy, init_done, error;
   logic [5:0] err_index;

   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   go_cyc = 0;
   int   txn_in_run = 0;
   int   push_in_run = 0;
   int   rise0 = 0, rise1 = 0, last_rise = 0, last_width = 0;
   logic start_prev = 1'b0;
   int   done_dly = 20;
   int   done_hold = 2;
   bit   bfm_never = 1'b0;
   bit   bfm_bad11 = 1'b0;
   logic [7:0] mem [256];
   txn_t exp_q [$];

   sccb_init_sequencer #(
      .CLK_FREQ     (8_000_000),
      .TICKS_PER_MS (10),
      .DEV_ADDR_W   (8'h42),
      .ROM_AW       (6),
      .TIMEOUT_CYC  (50)
   ) dut (
      .PCLK      (PCLK),
      .PRESETN   (PRESETN),
      .go        (go),
      .start     (start),
      .rw        (rw),
      .ip_addr   (ip_addr),
      .sub_addr  (sub_addr),
      .data_in   (data_in),
      .done      (done),
      .data_out  (data_out),
      .busy      (busy),
      .init_done (init_done),
      .error     (error),
      .err_index (err_index)
   );

   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic begin_run();
      exp_q.delete();
      push_in_run = 0;
   endtask

   task automatic push_w(input logic [7:0] sub, input logic [7:0] dat);
      txn_t t;
      t = '{ip: 8'h42, rw: 1'b0, sub: sub, dat: dat};
      exp_q.push_back(t);
      push_in_run++;
`ifdef SCCB_VERIFY_EN
      if (!(sub == 8'h12 && dat[7])) begin
         t = '{ip: 8'h43, rw: 1'b1, sub: sub, dat: dat};
         exp_q.push_back(t);
         push_in_run++;
      end
`endif
   endtask

   task automatic push_table();
      push_w(8'h12, 8'h80);
      push_w(8'h11, 8'h01);
      push_w(8'h12, 8'h14);
   endtask

   task automatic pulse_go(input bit new_run);
      @(negedge PCLK);
      go = 1'b1;
      if (new_run) begin
         go_cyc     = cyc;
         txn_in_run = 0;
      end
      repeat (2) @(negedge PCLK);
      go = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      repeat (2) @(negedge PCLK);
      while (busy && n < budget) begin
         @(negedge PCLK);
         n++;
      end
      if (busy) chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   // Transaction monitor: pops the scoreboard on every start rising edge
   always @(negedge PCLK) begin : mon
      txn_t got, exp;
      if (start && !start_prev) begin
         if (txn_in_run == 0) begin
            chk("go_to_start", 32'(cyc - go_cyc), 32'd3);
            rise0 = cyc;
         end
         if (txn_in_run == 1) rise1 = cyc;
         last_rise = cyc;
         chk("done_low_at_start", 32'(done), 32'd0);
         chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            got = '{ip: ip_addr, rw: rw, sub: sub_addr, dat: data_in};
            if (exp.rw)
               chk("txn_rd", 32'({got.ip, got.rw, got.sub}), 32'({exp.ip, exp.rw, exp.sub}));
            else
               chk("txn_wr", 32'(got), 32'(exp));
         end
         txn_in_run++;
      end
      if (!start && start_prev) last_width = cyc - last_rise;
      start_prev = start;
   end

   // CoreSCCB stand-in: done after done_dly cycles, held done_hold cycles
   initial begin : bfm
      logic [7:0] s, wd;
      logic       is_rd;
      done = 1'b0;
      data_out = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      forever begin
         @(negedge PCLK);
         if (start && !bfm_never && PRESETN) begin
            s     = sub_addr;
            wd    = data_in;
            is_rd = rw;
            repeat (done_dly - 1) @(negedge PCLK);
            done = 1'b1;
            if (is_rd) data_out = (bfm_bad11 && s == 8'h11) ? 8'h00 : mem[s];
            else       mem[s] = wd;
            repeat (done_hold) @(negedge PCLK);
            done = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n;
      PRESETN = 1'b0;
      go      = 1'b0;
      repeat (3) @(negedge PCLK);
      chk("rst_start",     32'(start),     32'd0);
      chk("rst_rw",        32'(rw),        32'd0);
      chk("rst_ip_addr",   32'(ip_addr),   32'd0);
      chk("rst_sub_addr",  32'(sub_addr),  32'd0);
      chk("rst_data_in",   32'(data_in),   32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_error",     32'(error),     32'd0);
      chk("rst_err_index", 32'(err_index), 32'd0);
      PRESETN = 1'b1;
      repeat (3) @(negedge PCLK);

      // Nominal run through the whole table
      begin_run();
      push_table();
      pulse_go(1'b1);
      wait_idle(3000);
      chk("nom_txn_count", 32'(txn_in_run), 32'(push_in_run));
      chk("nom_sb_empty",  32'(exp_q.size()), 32'd0);
      chk("nom_dly_gap",   32'((rise1 - rise0) >= 100), 32'd1);
      chk("nom_init_done", 32'(init_done), 32'd1);
      chk("nom_busy",      32'(busy),      32'd0);
      chk("nom_error",     32'(error),     32'd0);

      // Timeout on the first entry
      bfm_never = 1'b1;
      begin_run();
      push_w(8'h12, 8'h80);
      pulse_go(1'b1);
      wait_idle(3000);
      chk("tmo_txn_count", 32'(txn_in_run), 32'(push_in_run));
      chk("tmo_width",     32'(last_width), 32'd50);
      chk("tmo_error",     32'(error),      32'd1);
      chk("tmo_err_index", 32'(err_index),  32'd0);
      chk("tmo_busy",      32'(busy),       32'd0);
      chk("tmo_init_done", 32'(init_done),  32'd0);
      bfm_never = 1'b0;
      repeat (5) @(negedge PCLK);

      // Restart after error, with a stray go mid-sequence
      begin_run();
      push_table();
      pulse_go(1'b1);
      chk("rst_go_error_clr", 32'(error), 32'd0);
      chk("rst_go_busy",      32'(busy),  32'd1);
      repeat (30) @(negedge PCLK);
      pulse_go(1'b0);
      wait_idle(3000);
      chk("rerun_txn_count", 32'(txn_in_run), 32'(push_in_run));
      chk("rerun_sb_empty",  32'(exp_q.size()), 32'd0);
      chk("rerun_init_done", 32'(init_done), 32'd1);
      chk("rerun_error",     32'(error),     32'd0);

      // Level done held for 30 cycles
      done_hold = 30;
      begin_run();
      push_table();
      pulse_go(1'b1);
      wait_idle(5000);
      chk("lvl_txn_count", 32'(txn_in_run), 32'(push_in_run));
      chk("lvl_init_done", 32'(init_done), 32'd1);
      done_hold = 2;
      repeat (40) @(negedge PCLK);

      // Asynchronous reset 5 cycles into the second transaction
      begin_run();
      push_table();
      pulse_go(1'b1);
      n = 0;
      while (txn_in_run < 2 && n < 2000) begin
         @(negedge PCLK);
         n++;
      end
      if (txn_in_run < 2) chk("ar_wait_txn2", 32'(txn_in_run), 32'd2);
      repeat (5) @(negedge PCLK);
      #2;
      PRESETN = 1'b0;
      #1;
      chk("ar_start",     32'(start),     32'd0);
      chk("ar_busy",      32'(busy),      32'd0);
      chk("ar_init_done", 32'(init_done), 32'd0);
      chk("ar_error",     32'(error),     32'd0);
      chk("ar_err_index", 32'(err_index), 32'd0);
      repeat (40) @(negedge PCLK);
      PRESETN = 1'b1;
      repeat (5) @(negedge PCLK);
      begin_run();
      push_table();
      pulse_go(1'b1);
      wait_idle(3000);
      chk("ar_rerun_txn_count", 32'(txn_in_run), 32'(push_in_run));
      chk("ar_rerun_sb_empty",  32'(exp_q.size()), 32'd0);
      chk("ar_rerun_init_done", 32'(init_done), 32'd1);

`ifdef SCCB_VERIFY_EN
      // Readback of register 0x11 returns the wrong value
      repeat (5) @(negedge PCLK);
      bfm_bad11 = 1'b1;
      begin_run();
      push_w(8'h12, 8'h80);
      push_w(8'h11, 8'h01);
      pulse_go(1'b1);
      wait_idle(3000);
      chk("ver_txn_count", 32'(txn_in_run), 32'(push_in_run));
      chk("ver_error",     32'(error),      32'd1);
      chk("ver_err_index", 32'(err_index),  32'd2);
      chk("ver_init_done", 32'(init_done),  32'd0);
      bfm_bad11 = 1'b0;
`endif

      repeat (5) @(negedge PCLK);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
